hpm_counter_bank: RTL
=====================

// Module: hpm_counter_bank
//
// PURPOSE
// Parametrised bank of RISC-V hardware performance monitor counters, mhpmcounter3..(3+NumCounters-1).
// Supersedes the fixed 6-counter block. Adds multi-count increments per cycle (one per commit port),
// configurable counter width, per-privilege inhibit, sticky overflow flags, overflow summary CSR and
// overflow interrupt. Sits beside csr_regfile; the event fabric supplies per-event counts.
//
// PARAMETERS
// NumCounters   6   implemented counters, 1..29; index i maps to mhpmcounter(3+i)
// CounterWidth  64  counter bits, 32..64; bits above CounterWidth read 0
// NumEvents     32  event sources; selector width SelW = $clog2(NumEvents)
// EventCntW     2   width of each per-cycle event count (max count 2^EventCntW-1)
// XLEN          64  CSR data width, 32 or 64
//
// PORTS
// clk_i            in   1                     clock
// rst_i            in   1                     async reset, active high
// debug_mode_i     in   1                     1: hart in debug mode, no counting
// priv_lvl_i       in   2                     current privilege: 0=U, 1=S, 3=M
// mcountinhibit_i  in   32                    bit (3+i) inhibits counter i
// event_cnt_i      in   NumEvents*EventCntW   per-event count this cycle; event 0 is hardwired to 0
// addr_i           in   12                    CSR address
// we_i             in   1                     CSR write strobe
// data_i           in   XLEN                  CSR write data
// data_o           out  XLEN                  CSR read data, combinational from addr_i
// access_ex_o      out  1                     addressed CSR illegal for this config
// ovf_irq_o        out  1                     local counter overflow interrupt request (registered)
//
// BEHAVIOUR
// - Event register i layout:
//   [SelW-1:0] SEL; [XLEN-1] OF (sticky overflow); [XLEN-2] MINH; [XLEN-3] SINH; [XLEN-4] UINH.
//   All other bits read 0.
// - Reset: all counters 0, all event regs 0, count pipeline regs 0, ovf_irq_o 0.
// - Stage 1 (registered): inc_q[i] = event_cnt_i[SEL_i]. Then inc_q[i] = 0 if any of these hold:
//   debug_mode_i; mcountinhibit_i[3+i]; MINH and priv=M; SINH and priv=S; UINH and priv=U.
// - Stage 2: cnt_i <= cnt_i + inc_q[i], modulo 2^CounterWidth.
//   - Increment appears 2 cycles after the event.
// - Overflow: carry out of bit CounterWidth-1 sets OF_i the same cycle the counter wraps.
//   - OF stays set until a CSR write to event reg i writes 0 to bit XLEN-1.
// - ovf_irq_o <= |{OF_i}, one cycle after OF sets.
// - Address map, i = 0..NumCounters-1:
//   - mhpmcounter  0xB03+i: counter bits [XLEN-1:0].
//   - mhpmcounterh 0xB83+i: bits [63:32]; XLEN=32 only.
//   - mhpmevent    0x323+i: event register i.
//   - scountovf    0xDA0: read-only; bit (3+i) = OF_i, other bits 0.
// - Writes:
//   - Counter write: value truncated to CounterWidth.
//   - High-half write (XLEN=32): replaces bits [63:32].
//   - SEL values >= NumEvents: stored as 0 (WARL).
// - Write vs. increment, same counter, same cycle: the write wins and inc_q is discarded.
//   - No OF from a discarded increment.
//   - Other counters keep counting; no global we_i stall.
// - Unimplemented index (NumCounters <= i < 29): reads 0, writes ignored, no exception.
// - access_ex_o = 1 in any of these cases:
//   - Address outside the map.
//   - 0x?8? high halves when XLEN=64.
//   - Write to scountovf.
//   On access_ex_o = 1: state unchanged, data_o = 0.
// - Changing SEL: takes effect on the next stage-1 sample. The already registered inc_q still
//   applies the old event's count.
// - Async reset mid-operation: every register clears immediately; pending inc_q is dropped.
//
// TESTING
// - Reset: rst_i=1 mid-count -> all reads 0, ovf_irq_o=0.
//   Release, write SEL0=5, event5 count 2 for 3 cycles -> counter0 reads 6 two cycles after the last event.
// - Wrap: CounterWidth=48, write counter1 = 2^48-2, SEL=3, one cycle count 3 -> counter1=1, OF1=1,
//   scountovf=0x10, ovf_irq_o=1 next cycle.
//   Write event1 with bit XLEN-1=0 -> OF1=0, irq drops.
// - Filtering: MINH=1, priv=M, count 1 -> no change. priv=U -> +1.
//   mcountinhibit bit 4 set -> counter1 frozen. debug_mode_i=1 -> all counters frozen.
// - Collision: counter2 counting +1/cycle; write 0x100 -> reads 0x100 the next cycle, then 0x101,
//   0x102 (no lost or double count). Counter3 unaffected throughout.
// - XLEN=32: write 0xB83 = 0xDEAD, 0xB03 = 0xBEEF -> reads return 0xDEAD / 0xBEEF.
//   XLEN=64: access to 0xB83 -> access_ex_o=1, counter unchanged.
// - Bounds, NumCounters=4: 0xB08 reads 0, no exception.
//   SEL write 0x3F with NumEvents=32 -> reads back 0. Write 0xDA0 -> access_ex_o=1.

Source files
------------

// File: rtl/hpm_counter_bank.sv
// Bank of RISC-V mhpmcounter3..N performance counters with event select, privilege
// filtering, sticky overflow flags, scountovf summary and overflow interrupt.
module hpm_counter_bank #(
  parameter int unsigned NumCounters  = 6,
  parameter int unsigned CounterWidth = 64,
  parameter int unsigned NumEvents    = 32,
  parameter int unsigned EventCntW    = 2,
  parameter int unsigned XLEN         = 64
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           debug_mode_i,
  input  logic [1:0]                     priv_lvl_i,
  input  logic [31:0]                    mcountinhibit_i,
  input  logic [NumEvents*EventCntW-1:0] event_cnt_i,
  input  logic [11:0]                    addr_i,
  input  logic                           we_i,
  input  logic [XLEN-1:0]                data_i,
  output logic [XLEN-1:0]                data_o,
  output logic                           access_ex_o,
  output logic                           ovf_irq_o
);

  localparam int unsigned SelW      = (NumEvents > 1) ? $clog2(NumEvents) : 1;
  localparam int unsigned SelFieldW = XLEN - 4;
  localparam logic [11:0] CntBase   = 12'hB03;
  localparam logic [11:0] CntHBase  = 12'hB83;
  localparam logic [11:0] EvtBase   = 12'h323;
  localparam logic [11:0] OvfAddr   = 12'hDA0;
  localparam logic [11:0] LastOff   = 12'd28;
  localparam logic        HasHigh   = (XLEN == 32);
  localparam logic [63:0] LoMask    = (XLEN == 64) ? {64{1'b1}} : 64'h0000_0000_FFFF_FFFF;

  logic [CounterWidth-1:0] cnt_q [NumCounters];
  logic [CounterWidth-1:0] cnt_d [NumCounters];
  logic [SelW-1:0]         sel_q [NumCounters];
  logic [SelW-1:0]         sel_d [NumCounters];
  logic [EventCntW-1:0]    inc_q [NumCounters];
  logic [EventCntW-1:0]    inc_d [NumCounters];
  logic [NumCounters-1:0]  of_q, of_d, minh_q, minh_d, sinh_q, sinh_d, uinh_q, uinh_d;
  logic                    ovf_irq_q, ovf_irq_d;

  logic                    hit_cnt, hit_cnth, hit_evt, hit_ovf, wr_ok;
  logic [4:0]              idx;
  logic [SelW-1:0]         wsel;
  logic                    unused_inhibit;

  assign unused_inhibit = ^mcountinhibit_i;
  assign ovf_irq_o      = ovf_irq_q;

  // Address decode and legality check
  always_comb begin
    hit_cnt  = 1'b0;
    hit_cnth = 1'b0;
    hit_evt  = 1'b0;
    hit_ovf  = (addr_i == OvfAddr);
    idx      = '0;
    if (addr_i >= CntBase && addr_i <= CntBase + LastOff) begin
      hit_cnt = 1'b1;
      idx     = 5'(addr_i - CntBase);
    end else if (addr_i >= CntHBase && addr_i <= CntHBase + LastOff) begin
      hit_cnth = 1'b1;
      idx      = 5'(addr_i - CntHBase);
    end else if (addr_i >= EvtBase && addr_i <= EvtBase + LastOff) begin
      hit_evt = 1'b1;
      idx     = 5'(addr_i - EvtBase);
    end
    access_ex_o = !(hit_cnt || (hit_cnth && HasHigh) || hit_evt || (hit_ovf && !we_i));
    wr_ok       = we_i && !access_ex_o;
  end

  // Out-of-range selectors (judged on the whole non-flag field) collapse to event 0
  assign wsel = (data_i[SelFieldW-1:0] < SelFieldW'(NumEvents)) ? data_i[SelW-1:0] : '0;

  // Next state: stage-1 event sampling, stage-2 accumulate, CSR writes, overflow
  always_comb begin
    logic [CounterWidth:0] sum;
    logic [63:0]           cur64;
    logic                  carry;
    logic                  ev_wr;
    logic                  blocked;
    ovf_irq_d = |of_q;
    for (int i = 0; i < NumCounters; i++) begin
      cur64    = 64'(cnt_q[i]);
      sum      = {1'b0, cnt_q[i]} + (CounterWidth+1)'(inc_q[i]);
      cnt_d[i] = sum[CounterWidth-1:0];
      carry    = sum[CounterWidth];
      if (wr_ok && hit_cnt && int'(idx) == i) begin
        cnt_d[i] = CounterWidth'((cur64 & ~LoMask) | (64'(data_i) & LoMask));
        carry    = 1'b0;
      end else if (wr_ok && hit_cnth && int'(idx) == i) begin
        cnt_d[i] = CounterWidth'({data_i[31:0], cur64[31:0]});
        carry    = 1'b0;
      end
      ev_wr     = wr_ok && hit_evt && int'(idx) == i;
      sel_d[i]  = ev_wr ? wsel : sel_q[i];
      minh_d[i] = ev_wr ? data_i[XLEN-2] : minh_q[i];
      sinh_d[i] = ev_wr ? data_i[XLEN-3] : sinh_q[i];
      uinh_d[i] = ev_wr ? data_i[XLEN-4] : uinh_q[i];
      of_d[i]   = (ev_wr ? data_i[XLEN-1] : of_q[i]) | carry;

      inc_d[i] = '0;
      if (sel_q[i] != '0 && 32'(sel_q[i]) < NumEvents) begin
        inc_d[i] = event_cnt_i[32'(sel_q[i])*EventCntW +: EventCntW];
      end
      blocked = debug_mode_i || mcountinhibit_i[3+i]
             || (minh_q[i] && priv_lvl_i == 2'd3)
             || (sinh_q[i] && priv_lvl_i == 2'd1)
             || (uinh_q[i] && priv_lvl_i == 2'd0);
      if (blocked) inc_d[i] = '0;
    end
  end

  // Read mux; unimplemented indices fall through as zero
  always_comb begin
    logic [63:0] cur64;
    data_o = '0;
    for (int i = 0; i < NumCounters; i++) begin
      cur64 = 64'(cnt_q[i]);
      if (int'(idx) == i && !access_ex_o) begin
        if (hit_cnt)  data_o = XLEN'(cur64);
        if (hit_cnth) data_o = XLEN'(cur64[63:32]);
        if (hit_evt) begin
          data_o[SelW-1:0] = sel_q[i];
          data_o[XLEN-1]   = of_q[i];
          data_o[XLEN-2]   = minh_q[i];
          data_o[XLEN-3]   = sinh_q[i];
          data_o[XLEN-4]   = uinh_q[i];
        end
      end
      if (hit_ovf && !access_ex_o) data_o[3+i] = of_q[i];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NumCounters; i++) begin
        cnt_q[i] <= '0;
        sel_q[i] <= '0;
        inc_q[i] <= '0;
      end
      of_q      <= '0;
      minh_q    <= '0;
      sinh_q    <= '0;
      uinh_q    <= '0;
      ovf_irq_q <= 1'b0;
    end else begin
      for (int i = 0; i < NumCounters; i++) begin
        cnt_q[i] <= cnt_d[i];
        sel_q[i] <= sel_d[i];
        inc_q[i] <= inc_d[i];
      end
      of_q      <= of_d;
      minh_q    <= minh_d;
      sinh_q    <= sinh_d;
      uinh_q    <= uinh_d;
      ovf_irq_q <= ovf_irq_d;
    end
  end

endmodule
